// File: rtl/vec_addsub_sequencer_if.sv
// Bundle for the vector add/sub sequencer: requester handshake, operand/result
// vectors, and the lane-serial port to the shared complement+adder slice.
interface vec_addsub_sequencer_if #(
  parameter int WIDTH = 19,
  parameter int LANES = 4
);
  logic                   start;
  logic                   op_sub;
  logic [LANES-1:0]       lane_mask;
  logic [LANES*WIDTH-1:0] a_vec;
  logic [LANES*WIDTH-1:0] b_vec;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [LANES*WIDTH-1:0] result_vec;
  logic [LANES-1:0]       cout_vec;
  logic [LANES-1:0]       ovf_vec;
  logic [WIDTH-1:0]       dp_a;
  logic [WIDTH-1:0]       dp_b;
  logic                   dp_subs;
  logic                   dp_cin;
  logic [WIDTH-1:0]       dp_sum;
  logic                   dp_cout;
  logic [1:0]             fsm_state;

  // Handshake: an op is accepted on a rising edge where start=1 and ready=1;
  // done pulses for one cycle when result/cout/ovf vectors are valid.
  modport slave (
    input  start, op_sub, lane_mask, a_vec, b_vec, dp_sum, dp_cout,
    output ready, busy, done, result_vec, cout_vec, ovf_vec,
           dp_a, dp_b, dp_subs, dp_cin, fsm_state
  );

  modport master (
    output start, op_sub, lane_mask, a_vec, b_vec, dp_sum, dp_cout,
    input  ready, busy, done, result_vec, cout_vec, ovf_vec,
           dp_a, dp_b, dp_subs, dp_cin, fsm_state
  );
endinterface

// File: rtl/vec_addsub_sequencer.sv
// Serialises a LANES-wide vector add/subtract through one shared WIDTH-bit
// complement+adder slice, one lane per cycle, with a start/done handshake.
module vec_addsub_sequencer #(
  parameter int WIDTH = 19,
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst,
  vec_addsub_sequencer_if.slave bus
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          lane;
  logic [LANES*WIDTH-1:0] a_q, b_q, res_q;
  logic                   sub_q;
  logic [LANES-1:0]       mask_q, cout_q, ovf_q;

  logic                   accept, last_lane, lane_on;
  logic [WIDTH-1:0]       lane_a, lane_b, lane_res;
  logic                   lane_cout, lane_ovf, sa, sb, ss;
  logic [WIDTH-1:0]       dp_a_d, dp_b_d;
  logic                   dp_subs_d;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    lane_a    = a_q[int'(lane)*WIDTH +: WIDTH];
    lane_b    = b_q[int'(lane)*WIDTH +: WIDTH];
    lane_on   = mask_q[lane];
    last_lane = (lane == CW'(LANES - 1));
    sa        = lane_a[WIDTH-1];
    sb        = lane_b[WIDTH-1];
    ss        = bus.dp_sum[WIDTH-1];
    dp_a_d    = '0;
    dp_b_d    = '0;
    dp_subs_d = 1'b0;
    lane_res  = lane_a;
    lane_cout = 1'b0;
    lane_ovf  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // Masked lanes keep the slice quiet and pass A straight through.
        if (lane_on) begin
          dp_a_d    = lane_a;
          dp_b_d    = lane_b;
          dp_subs_d = sub_q;
          lane_res  = bus.dp_sum;
          lane_cout = bus.dp_cout;
          lane_ovf  = sub_q ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        end
        if (last_lane) state_nx = DONE;
      end
      DONE: begin
        accept   = bus.start;
        state_nx = bus.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      lane   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      mask_q <= '0;
      res_q  <= '0;
      cout_q <= '0;
      ovf_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= bus.a_vec;
        b_q    <= bus.b_vec;
        sub_q  <= bus.op_sub;
        mask_q <= bus.lane_mask;
        lane   <= '0;
      end else if (state == RUN) begin
        res_q[int'(lane)*WIDTH +: WIDTH] <= lane_res;
        cout_q[lane] <= lane_cout;
        ovf_q[lane]  <= lane_ovf;
        lane         <= last_lane ? '0 : lane + CW'(1);
      end
    end
  end

  assign bus.ready      = (state == IDLE) || (state == DONE);
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.result_vec = res_q;
  assign bus.cout_vec   = cout_q;
  assign bus.ovf_vec    = ovf_q;
  assign bus.dp_a       = dp_a_d;
  assign bus.dp_b       = dp_b_d;
  assign bus.dp_subs    = dp_subs_d;
  assign bus.dp_cin     = dp_subs_d;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_vec_addsub_sequencer.sv
// Directed bench for vec_addsub_sequencer with a behavioural adder slice and
// an expected-result queue filled at launch and drained on done.
module tb_vec_addsub_sequencer;
  localparam int WIDTH = 19;
  localparam int LANES = 4;
  localparam int LW    = LANES * WIDTH;
  localparam int EW    = LW + 2 * LANES;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_addsub_sequencer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  vec_addsub_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // shared complement+adder slice, purely combinational
  logic [WIDTH:0] slice_full;
  always_comb begin
    slice_full  = {1'b0, bus.dp_a} + {1'b0, (bus.dp_subs ? ~bus.dp_b : bus.dp_b)}
                + {{WIDTH{1'b0}}, bus.dp_cin};
    bus.dp_sum  = slice_full[WIDTH-1:0];
    bus.dp_cout = slice_full[WIDTH];
  end

  // scoreboard
  logic [EW-1:0]    exp_q[$];
  int               total = 0;
  int               bad   = 0;
  logic [LW-1:0]    cur_a, cur_b;
  logic             cur_sub;
  logic [LANES-1:0] cur_mask;

  function automatic logic [LW-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    pack = {WIDTH'(v3), WIDTH'(v2), WIDTH'(v1), WIDTH'(v0)};
  endfunction

  function automatic logic [EW-1:0] model(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                          input logic sub, input logic [LANES-1:0] m);
    logic [LW-1:0]    r;
    logic [LANES-1:0] c, o;
    logic [WIDTH-1:0] ai, bi;
    int               s;
    r = '0; c = '0; o = '0;
    for (int i = 0; i < LANES; i++) begin
      ai = a[i*WIDTH +: WIDTH];
      bi = b[i*WIDTH +: WIDTH];
      if (!m[i]) begin
        r[i*WIDTH +: WIDTH] = ai;
      end else if (sub) begin
        r[i*WIDTH +: WIDTH] = ai - bi;
        c[i] = (ai >= bi);
        s = int'($signed(ai)) - int'($signed(bi));
        o[i] = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
      end else begin
        r[i*WIDTH +: WIDTH] = ai + bi;
        c[i] = (int'(ai) + int'(bi)) >= (1 << WIDTH);
        s = int'($signed(ai)) + int'($signed(bi));
        o[i] = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
      end
    end
    model = {r, c, o};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.a_vec     = LW'({$urandom(), $urandom(), $urandom()});
    bus.b_vec     = LW'({$urandom(), $urandom(), $urandom()});
    bus.op_sub    = 1'($urandom_range(0, 1));
    bus.lane_mask = LANES'($urandom_range(0, (1 << LANES) - 1));
  endtask

  // driver: present an op for one edge, then garble the don't-care operands
  task automatic launch(input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic sub, input logic [LANES-1:0] m);
    bus.start     = 1'b1;
    bus.a_vec     = a;
    bus.b_vec     = b;
    bus.op_sub    = sub;
    bus.lane_mask = m;
    cur_a = a; cur_b = b; cur_sub = sub; cur_mask = m;
    exp_q.push_back(model(a, b, sub, m));
    tick();
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 128'(bus.ready), 128'(1));
    chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
    chk({tag, "_done"}, 128'(bus.done), 128'(0));
    chk({tag, "_res"}, 128'(bus.result_vec), 128'(0));
    chk({tag, "_cout"}, 128'(bus.cout_vec), 128'(0));
    chk({tag, "_ovf"}, 128'(bus.ovf_vec), 128'(0));
    chk({tag, "_dp"}, 128'({bus.dp_a, bus.dp_b, bus.dp_subs, bus.dp_cin}), 128'(0));
  endtask

  // Called in cycle T+1; checks each RUN cycle's slice drive and done latency.
  task automatic wait_done(input string tag, input bit poke);
    int            cyc;
    logic [EW-1:0] e;
    logic          on;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (cyc <= LANES) begin
        on = cur_mask[cyc-1];
        chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
        chk({tag, "_dpa"}, 128'(bus.dp_a), on ? 128'(cur_a[(cyc-1)*WIDTH +: WIDTH]) : 128'(0));
        chk({tag, "_dpb"}, 128'(bus.dp_b), on ? 128'(cur_b[(cyc-1)*WIDTH +: WIDTH]) : 128'(0));
        chk({tag, "_dpsubs"}, 128'(bus.dp_subs), 128'(on & cur_sub));
        chk({tag, "_dpcin"}, 128'(bus.dp_cin), 128'(on & cur_sub));
      end
      if (poke && cyc == 2) begin
        bus.start = 1'b1;
        scramble();
      end
      if (poke && cyc == 3) bus.start = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(LANES + 1));
    if (bus.done === 1'b1) begin
      chk({tag, "_ready"}, 128'(bus.ready), 128'(1));
      chk({tag, "_qnonempty"}, 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_result"}, 128'({bus.result_vec, bus.cout_vec, bus.ovf_vec}), 128'(e));
      end
    end
  endtask

  initial begin
    logic [LW-1:0] ra, rb;
    bus.start = 1'b1;
    scramble();

    // reset held with start asserted
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_reset_state("reset");
    end
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_reset_idle", 128'({bus.ready, bus.busy}), 128'(2'b10));

    // add with a lane that overflows into the sign bit
    launch(pack(1, 100, 262143, 0), pack(2, 50, 1, 0), 1'b0, 4'hF);
    wait_done("add", 1'b0);
    chk("add_const_res", 128'(bus.result_vec), 128'(pack(3, 150, 262144, 0)));
    chk("add_const_ovf", 128'(bus.ovf_vec), 128'(4'b0100));
    chk("add_const_cout", 128'(bus.cout_vec), 128'(4'b0000));
    tick();
    chk("add_hold_done", 128'(bus.done), 128'(0));
    chk("add_hold_res", 128'(bus.result_vec), 128'(pack(3, 150, 262144, 0)));

    // subtract
    launch(pack(5, 0, 'h40000, 7), pack(3, 1, 1, 7), 1'b1, 4'hF);
    wait_done("sub", 1'b0);
    chk("sub_const_res", 128'(bus.result_vec), 128'(pack(2, 'h7FFFF, 'h3FFFF, 0)));
    chk("sub_const_cout", 128'(bus.cout_vec), 128'(4'b1101));
    chk("sub_const_ovf", 128'(bus.ovf_vec), 128'(4'b0100));
    tick();

    // lane mask pass-through
    launch(pack(10, 20, 30, 40), pack(1, 1, 1, 1), 1'b0, 4'b0101);
    wait_done("mask", 1'b0);
    chk("mask_const_res", 128'(bus.result_vec), 128'(pack(11, 20, 31, 40)));
    tick();

    // start during RUN ignored, then back-to-back launches from DONE
    ra = LW'({$urandom(), $urandom(), $urandom()});
    rb = LW'({$urandom(), $urandom(), $urandom()});
    launch(ra, rb, 1'b0, 4'hF);
    wait_done("poke", 1'b1);
    for (int k = 0; k < 6; k++) begin
      ra = LW'({$urandom(), $urandom(), $urandom()});
      rb = LW'({$urandom(), $urandom(), $urandom()});
      launch(ra, rb, 1'($urandom_range(0, 1)), LANES'($urandom_range(0, (1 << LANES) - 1)));
      wait_done("b2b", 1'b0);
    end
    tick();

    // reset during lane 2 of RUN
    launch(pack(9, 9, 9, 9), pack(1, 2, 3, 4), 1'b0, 4'hF);
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("midreset");
    void'(exp_q.pop_back());
    rst = 1'b1;
    repeat (6) begin
      tick();
      chk("midreset_nodone", 128'(bus.done), 128'(0));
    end
    launch(pack(100, 'h3FFFF, 'h40000, 77), pack(200, 'h3FFFF, 'h40000, 77), 1'b1, 4'b1011);
    wait_done("after_reset", 1'b0);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vec_addsub_sequencer.md
# vec_addsub_sequencer

Multi-cycle controller that runs a LANES-wide vector add/subtract through one shared WIDTH-bit complement+adder slice in the Execute ALU. It captures both operand vectors, drives the slice one lane per cycle with matching SUBS and carry-in, and collects per-lane sums, carry-out and signed-overflow flags. It reports completion with a start/done handshake, so the ALU reuses a single adder instead of replicating it per lane.

## Interface
- WIDTH, 19, bits per lane (matches the complement/adder slice)
- LANES, 4, number of lanes per vector op (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request new op; accepted only when ready=1
- op_sub  in  1  0 = A+B, 1 = A−B; sampled with start
- lane_mask  in  LANES  1 = lane computed, 0 = lane passes A through; sampled with start
- a_vec  in  LANES*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH]
- b_vec  in  LANES*WIDTH  operand B, same packing
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when results valid
- result_vec  out  LANES*WIDTH  lane sums, held until next accepted start
- cout_vec  out  LANES  per-lane adder carry-out
- ovf_vec  out  LANES  per-lane signed two's-complement overflow
- dp_a  out  WIDTH  to shared adder operand A
- dp_b  out  WIDTH  to complement block input (un-inverted B)
- dp_subs  out  1  to complement SUBS and used as adder carry-in
- dp_cin  out  1  adder carry-in (= dp_subs while running)
- dp_sum  in  WIDTH  adder sum, combinational from dp_* same cycle
- dp_cout  in  1  adder carry-out, combinational

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. start=1 → latch a_vec, b_vec, op_sub, lane_mask; lane counter=0; → RUN.
- RUN: drive dp_a=A[lane], dp_b=B[lane], dp_subs=dp_cin=op_sub. At clock edge store dp_sum into result lane, dp_cout into cout_vec[lane], computed overflow into ovf_vec[lane]; increment counter. After lane LANES−1 → DONE.
- Masked lane (mask=0): still takes one RUN cycle; dp_* driven to 0; result lane = latched A[lane]; cout=0; ovf=0.
- Overflow: sa, sb = sign bits of A, B lane; ss = sign of dp_sum. Add: ovf = (sa==sb)&&(ss!=sa). Sub: ovf = (sa!=sb)&&(ss!=sa).
- DONE: done=1 for exactly this cycle, ready=1. start=1 here is accepted as in IDLE (back-to-back) → RUN; else → IDLE.
- start while busy=1 is ignored; no queuing.
- Operand inputs are don't-care except in the cycle start is accepted.
- Outside RUN, dp_a=dp_b=0, dp_subs=dp_cin=0.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst=0 at edge): state=IDLE, ready=1, busy=0, done=0, result_vec=0, cout_vec=0, ovf_vec=0, all dp_* = 0, counter=0. Reset overrides start and aborts RUN mid-op; partial results are discarded (cleared).
- start accepted at edge T → RUN during cycles T+1..T+LANES → done=1 in cycle T+LANES+1.
- Throughput with back-to-back start in DONE: one op per LANES+1 cycles.
- result_vec/cout_vec/ovf_vec for lane i update at end of RUN cycle i; all lanes are stable when done=1 and hold until the end of lane 0 of the next op. Lanes not yet rewritten keep previous values during RUN.
- dp_sum/dp_cout are sampled in the same cycle dp_* are driven; no pipeline register in the slice is assumed.

## Test plan
- Reset: hold rst=0 3 cycles with start=1 → ready=1, busy=0, done=0, all outputs 0; no RUN entered.
- Add, LANES=4: A={1,100,262143,0}, B={2,50,1,0}, mask=4'hF, op_sub=0 → done at T+5; result={3,150,262144 (0x40000),0}; ovf lane2=1, others 0; cout all 0.
- Subtract: A={5,0,0x40000,7}, B={3,1,1,7} → result={2,0x7FFFF,0x3FFFF,0}; ovf only lane2; dp_subs=1 and dp_cin=1 throughout RUN; cout={1,0,1,1}.
- Mask: mask=4'b0101, A={10,20,30,40}, B={1,1,1,1} add → result={11,20,31,40}; lanes 1,3 ovf=0, cout=0, dp_*=0 in their cycles.
- Handshake: start pulsed during RUN is ignored (done still at T+5, operands unchanged); start in DONE cycle launches next op with next done exactly 5 cycles later.
- Reset mid-op: rst=0 during lane 2 of RUN → next cycle IDLE, results cleared, no done pulse; fresh start afterwards completes normally.
